// File: rtl/fpnew_issue_pkg.sv
// fpnew_issue_pkg: shared widths and request/metadata types for the FPU issue controller.
//   WIDTH    FP operand/result width (matches the FPU datapath width)
//   STATUS_W width of the {NV,DZ,OF,UF,NX} status vector
//   The enum encodings mirror those of fpnew_pkg, so the request fields map directly onto the FPU ports.
package fpnew_issue_pkg;
    localparam int WIDTH    = 64;
    localparam int STATUS_W = 5;

    typedef enum logic [2:0] {
        RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic [2:0][WIDTH-1:0] operands;
        roundmode_e            rnd_mode;
        operation_e            op;
        logic                  op_mod;
        fp_format_e            src_fmt;
        fp_format_e            dst_fmt;
        int_format_e           int_fmt;
    } fpu_req_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [7:0] instr_id;
        logic       is_fp_dest;
    } fpu_meta_t;
endpackage

// File: rtl/fpnew_issue_ctrl_lzc.sv
// lzc: trailing-zero counter; reports the index of the lowest set bit.
//   in_i    input vector
//   cnt_o   index of the lowest set bit of in_i (0 when in_i is all zero)
//   empty_o in_i has no bit set
module lzc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (in_i[i]) cnt_o = CNT_W'(i);
    end

    assign empty_o = ~|in_i;
endmodule

// File: rtl/fpnew_issue_ctrl.sv
// fpnew_issue_ctrl: issues tagged FP ops to the FPU and returns their results on a registered writeback port.
//   clk_i/rst_ni                     clock, synchronous active-low reset
//   req_*                            issue-side request (valid/ready, operation, destination metadata)
//   flush_i                          kill every op in flight
//   fpu_in_*/fpu_req_o/fpu_tag_o     FPU input handshake, operation and allocated tag
//   fpu_flush_o                      flush forwarded to the FPU
//   fpu_out_*/fpu_result_i/status/tag FPU result handshake
//   wb_*                             registered writeback entry with the metadata of its tag
//   fflags_o/fflags_clr_i            sticky exception flags and their CSR clear
//   busy_o                           any op in flight or writeback pending
//   err_tag_o                        sticky: a result arrived for a tag that was not in flight
module fpnew_issue_ctrl
    import fpnew_issue_pkg::*;
#(
    parameter int NumTags  = 4,
    parameter int TagWidth = $clog2(NumTags)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  fpu_req_t            req_op_i,
    input  fpu_meta_t           req_meta_i,
    input  logic                flush_i,
    output logic                fpu_in_valid_o,
    input  logic                fpu_in_ready_i,
    output fpu_req_t            fpu_req_o,
    output logic [TagWidth-1:0] fpu_tag_o,
    output logic                fpu_flush_o,
    input  logic                fpu_out_valid_i,
    output logic                fpu_out_ready_o,
    input  logic [WIDTH-1:0]    fpu_result_i,
    input  logic [STATUS_W-1:0] fpu_status_i,
    input  logic [TagWidth-1:0] fpu_tag_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [WIDTH-1:0]    wb_result_o,
    output logic [STATUS_W-1:0] wb_status_o,
    output fpu_meta_t           wb_meta_o,
    output logic [STATUS_W-1:0] fflags_o,
    input  logic                fflags_clr_i,
    output logic                busy_o,
    output logic                err_tag_o
);
    logic [NumTags-1:0]  inflight_q, inflight_d;
    fpu_meta_t           meta_q [NumTags];
    logic                wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]    wb_result_q, wb_result_d;
    logic [STATUS_W-1:0] wb_status_q, wb_status_d;
    fpu_meta_t           wb_meta_q, wb_meta_d;
    logic [STATUS_W-1:0] fflags_q, fflags_d;
    logic                err_q, err_d;
    logic [TagWidth-1:0] free_tag;
    logic                none_free, res_hs, res_hit, wb_hs;

    // Lowest free tag, from registered state only: a tag freed this cycle is reusable next cycle.
    lzc #(.WIDTH(NumTags), .CNT_W(TagWidth)) i_lzc (
        .in_i    (~inflight_q),
        .cnt_o   (free_tag),
        .empty_o (none_free)
    );

    assign fpu_flush_o     = flush_i;
    assign fpu_req_o       = req_op_i;
    assign fpu_tag_o       = free_tag;
    assign fpu_in_valid_o  = req_valid_i & ~none_free & ~flush_i;
    assign req_ready_o     = fpu_in_valid_o & fpu_in_ready_i;
    // Single writeback register; a new result may enter on the cycle the old one pops.
    assign fpu_out_ready_o = (~wb_valid_q | wb_ready_i) & ~flush_i;
    assign res_hs          = fpu_out_valid_i & fpu_out_ready_o;
    assign res_hit         = res_hs & (int'(fpu_tag_i) < NumTags) & inflight_q[fpu_tag_i];
    assign wb_hs           = wb_valid_q & wb_ready_i;

    always_comb begin
        inflight_d  = inflight_q;
        wb_valid_d  = wb_valid_q & ~wb_ready_i;
        wb_result_d = wb_result_q;
        wb_status_d = wb_status_q;
        wb_meta_d   = wb_meta_q;
        // Accept and retire never touch the same tag: accept uses a tag that is not in flight.
        if (req_ready_o) inflight_d[free_tag] = 1'b1;
        if (res_hit) begin
            inflight_d[fpu_tag_i] = 1'b0;
            wb_valid_d            = 1'b1;
            wb_result_d           = fpu_result_i;
            wb_status_d           = fpu_status_i;
            wb_meta_d             = meta_q[fpu_tag_i];
        end
        if (flush_i) begin
            inflight_d = '0;
            wb_valid_d = 1'b0;
        end
        fflags_d = fflags_clr_i ? '0 : wb_hs ? fflags_q | wb_status_q : fflags_q;
        err_d    = err_q | (res_hs & ~res_hit);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_status_q <= '0;
            wb_meta_q   <= '0;
            fflags_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_status_q <= wb_status_d;
            wb_meta_q   <= wb_meta_d;
            fflags_q    <= fflags_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_ready_o) meta_q[free_tag] <= req_meta_i;
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_result_o = wb_result_q;
    assign wb_status_o = wb_status_q;
    assign wb_meta_o   = wb_meta_q;
    assign fflags_o    = fflags_q;
    assign err_tag_o   = err_q;
    assign busy_o      = |inflight_q | wb_valid_q;
endmodule
